byte_packer32: RTL and testbench

BYTE_PACKER32 -- requirements
Module: byte_packer32

---
 rtl/byte_packer32_if.sv | 23 ++
 rtl/byte_packer32.sv | 97 +++++++++
 tb/tb_byte_packer32.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/byte_packer32_if.sv
// Handshake and data bundle between byte_packer32, its upstream
// byte selector and the downstream word consumer.
interface byte_packer32_if;
    logic        start;
    logic [7:0]  mux_in;
    logic [1:0]  sel_out;
    logic        busy;
    logic [31:0] word_out;
    logic        word_valid;
    logic        word_ready;

    // Environment side: drives requests and bytes, consumes words.
    modport master (
        output start, mux_in, word_ready,
        input  sel_out, busy, word_out, word_valid
    );

    // Packer side.
    modport slave (
        input  start, mux_in, word_ready,
        output sel_out, busy, word_out, word_valid
    );
endinterface

// File: rtl/byte_packer32.sv
// Collects four bytes from a registered 4:1 selector into one word,
// then holds the word until the consumer accepts it.
module byte_packer32 #(
    parameter int LAT       = 2,
    parameter bit MSB_FIRST = 1'b0
) (
    input logic       clk,
    input logic       rst_n,
    byte_packer32_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    localparam logic [1:0] TLAST = 2'(LAT - 1);

    state_t      st, st_n;
    logic [1:0]  sel, sel_n;
    logic [1:0]  ccnt, ccnt_n;
    logic [1:0]  tcnt, tcnt_n;
    logic        busy, busy_n;
    logic        vld, vld_n;
    logic [31:0] word, word_n;
    logic        go;

    // Next state: issue selects, capture lanes after LAT edges, hold.
    always_comb begin
        st_n   = st;
        sel_n  = sel;
        ccnt_n = ccnt;
        tcnt_n = tcnt;
        busy_n = busy;
        vld_n  = vld;
        word_n = word;
        go     = 1'b0;
        unique case (st)
            IDLE: go = bus.start;
            RUN: begin
                if (sel != 2'd3)
                    sel_n = sel + 2'd1;
                if (tcnt != TLAST) begin
                    tcnt_n = tcnt + 2'd1;
                end else begin
                    for (int k = 0; k < 4; k++)
                        if (ccnt == 2'(k))
                            word_n[8*(MSB_FIRST ? 3-k : k) +: 8] = bus.mux_in;
                    if (ccnt == 2'd3) begin
                        st_n   = HOLD;
                        busy_n = 1'b0;
                        vld_n  = 1'b1;
                    end else begin
                        ccnt_n = ccnt + 2'd1;
                    end
                end
            end
            HOLD: begin
                if (bus.word_ready) begin
                    vld_n = 1'b0;
                    st_n  = IDLE;
                    go    = bus.start;
                end
            end
            default: st_n = IDLE;
        endcase
        if (go) begin
            st_n   = RUN;
            sel_n  = 2'd0;
            busy_n = 1'b1;
            ccnt_n = 2'd0;
            tcnt_n = 2'd0;
        end
    end

    // State register; reset clears everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st   <= IDLE;
            sel  <= 2'd0;
            ccnt <= 2'd0;
            tcnt <= 2'd0;
            busy <= 1'b0;
            vld  <= 1'b0;
            word <= 32'd0;
        end else begin
            st   <= st_n;
            sel  <= sel_n;
            ccnt <= ccnt_n;
            tcnt <= tcnt_n;
            busy <= busy_n;
            vld  <= vld_n;
            word <= word_n;
        end
    end

    assign bus.sel_out    = sel;
    assign bus.busy       = busy;
    assign bus.word_valid = vld;
    assign bus.word_out   = word;
endmodule

// File: tb/tb_byte_packer32.sv
// Bench: four packer builds (default, MSB first, LAT=1, LAT=3) share
// one stimulus; each has an upstream selector matched to its latency.
module tb_byte_packer32;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       rdy = 1'b0;
    logic [7:0] din [4];

    logic [1:0]  sel_o [4];
    logic        busy_o [4];
    logic        vld_o [4];
    logic [31:0] word_o [4];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : u
        localparam int L = (g == 2) ? 1 : ((g == 3) ? 3 : 2);
        localparam bit M = (g == 1);
        byte_packer32_if bus();
        logic [7:0] m, p0, p1;
        assign bus.start      = start;
        assign bus.word_ready = rdy;
        assign m = din[bus.sel_out];
        always_ff @(posedge clk) begin
            p0 <= m;
            p1 <= p0;
        end
        assign bus.mux_in = (L == 1) ? m : ((L == 2) ? p0 : p1);
        byte_packer32 #(.LAT(L), .MSB_FIRST(M)) dut (
            .clk(clk),
            .rst_n(rst_n),
            .bus(bus)
        );
        assign sel_o[g]  = bus.sel_out;
        assign busy_o[g] = bus.busy;
        assign vld_o[g]  = bus.word_valid;
        assign word_o[g] = bus.word_out;
    end

    typedef struct {
        logic        st;
        logic        rdy;
        logic [31:0] d;
        logic [1:0]  sel;
        logic        busy;
        logic        vld;
        logic [31:0] w;
        logic        v1;
        logic        v3;
        logic [31:0] wx;
    } vec_t;

    vec_t tbl [$];

    localparam logic [31:0] D1 = 32'h44332211;
    localparam logic [31:0] DX = 32'h88776655;
    localparam logic [31:0] DY = 32'hDDCCBBAA;

    function automatic logic [31:0] swap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic add(input logic s, input logic r, input logic [31:0] d,
                       input logic [1:0] sl, input logic b, input logic v,
                       input logic [31:0] w, input logic v1,
                       input logic v3, input logic [31:0] wx);
        vec_t x;
        x = '{s, r, d, sl, b, v, w, v1, v3, wx};
        tbl.push_back(x);
    endtask

    task automatic setd(input logic [31:0] d);
        for (int k = 0; k < 4; k++) din[k] = d[8*k +: 8];
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        setd(D1);
        // single word, then backpressure with start toggling
        add(1, 0, D1, 0, 1, 0, 32'h0,        0, 0, 0);
        add(0, 0, D1, 1, 1, 0, 32'h0,        0, 0, 0);
        add(0, 0, D1, 2, 1, 0, 32'h11,       0, 0, 0);
        add(0, 0, D1, 3, 1, 0, 32'h2211,     0, 0, 0);
        add(0, 0, D1, 3, 1, 0, 32'h332211,   1, 0, D1);
        add(0, 0, D1, 3, 0, 1, D1,           1, 0, D1);
        add(1, 0, D1, 3, 0, 1, D1,           1, 1, D1);
        for (int i = 7; i < 16; i++)
            add(1'(i % 2), 0, DX, 3, 0, 1, D1, 1, 1, D1);
        // back-to-back restart from HOLD; start in RUN ignored
        add(1, 1, DY, 0, 1, 0, D1,           0, 0, 0);
        add(0, 0, DY, 1, 1, 0, D1,           0, 0, 0);
        add(1, 0, DY, 2, 1, 0, 32'h443322AA, 0, 0, 0);
        add(0, 0, DY, 3, 1, 0, 32'h4433BBAA, 0, 0, 0);
        add(0, 0, DY, 3, 1, 0, 32'h44CCBBAA, 1, 0, DY);
        add(0, 0, DY, 3, 0, 1, DY,           1, 0, DY);
        add(0, 0, DY, 3, 0, 1, DY,           1, 1, DY);
        add(0, 1, DY, 3, 0, 0, DY,           0, 0, 0);
        add(0, 1, DY, 3, 0, 0, DY,           0, 0, 0);

        #12;
        for (int g = 0; g < 4; g++) begin
            chk($sformatf("rst_sel%0d", g), 32'(sel_o[g]), 0);
            chk($sformatf("rst_busy%0d", g), 32'(busy_o[g]), 0);
            chk($sformatf("rst_vld%0d", g), 32'(vld_o[g]), 0);
            chk($sformatf("rst_word%0d", g), word_o[g], 0);
        end
        #21;
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            start = tbl[i].st;
            rdy   = tbl[i].rdy;
            setd(tbl[i].d);
            step();
            chk($sformatf("v%0d_sel", i), 32'(sel_o[0]), 32'(tbl[i].sel));
            chk($sformatf("v%0d_busy", i), 32'(busy_o[0]), 32'(tbl[i].busy));
            chk($sformatf("v%0d_vld", i), 32'(vld_o[0]), 32'(tbl[i].vld));
            chk($sformatf("v%0d_word", i), word_o[0], tbl[i].w);
            chk($sformatf("v%0d_msbword", i), word_o[1], swap(tbl[i].w));
            chk($sformatf("v%0d_msbvld", i), 32'(vld_o[1]), 32'(tbl[i].vld));
            chk($sformatf("v%0d_l1vld", i), 32'(vld_o[2]), 32'(tbl[i].v1));
            chk($sformatf("v%0d_l3vld", i), 32'(vld_o[3]), 32'(tbl[i].v3));
            if (tbl[i].v1)
                chk($sformatf("v%0d_l1word", i), word_o[2], tbl[i].wx);
            if (tbl[i].v3)
                chk($sformatf("v%0d_l3word", i), word_o[3], tbl[i].wx);
        end

        // asynchronous reset in the middle of a transaction
        start = 1'b0;
        rdy   = 1'b0;
        setd(D1);
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk("mid_sel", 32'(sel_o[0]), 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_sel", 32'(sel_o[0]), 0);
        chk("arst_busy", 32'(busy_o[0]), 0);
        chk("arst_vld", 32'(vld_o[0]), 0);
        chk("arst_word", word_o[0], 0);
        chk("arst_l3busy", 32'(busy_o[3]), 0);
        step();
        step();
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk($sformatf("novld%0d", i), 32'(vld_o[0] | vld_o[3]), 0);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        chk("re_sel", 32'(sel_o[0]), 0);
        chk("re_busy", 32'(busy_o[0]), 1);
        for (int i = 1; i < 5; i++) step();
        chk("re_vld4", 32'(vld_o[0]), 0);
        chk("re_l1vld4", 32'(vld_o[2]), 1);
        chk("re_l1word", word_o[2], D1);
        step();
        chk("re_vld5", 32'(vld_o[0]), 1);
        chk("re_busy5", 32'(busy_o[0]), 0);
        chk("re_word", word_o[0], D1);
        chk("re_msbword", word_o[1], 32'h11223344);
        chk("re_l3vld5", 32'(vld_o[3]), 0);
        step();
        chk("re_l3vld6", 32'(vld_o[3]), 1);
        chk("re_l3word", word_o[3], D1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
